cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 24 ++
 rtl/cpu_sequencer.sv | 115 +++++++++++
 tb/tb_cpu_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the instruction sequencer and its environment.
// The slave modport is the sequencer; the master modport drives run/opa/mem_rdy.
interface cpu_sequencer_if;
  logic        run;
  logic [5:0]  opa;
  logic        mem_rdy;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic        dm_we;
  logic [2:0]  state;
  logic        busy;
  logic [15:0] instr_cnt;

  modport slave (
    input  run, opa, mem_rdy,
    output ir_we, pc_we, rf_we, dm_we, state, busy, instr_cnt
  );

  modport master (
    output run, opa, mem_rdy,
    input  ir_we, pc_we, rf_we, dm_we, state, busy, instr_cnt
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer with a retired-instruction counter.
// Optional macro MEM_WAIT_EN: MEM stalls until mem_rdy=1 instead of lasting one cycle.
module cpu_sequencer (
  input  logic           clk,
  input  logic           rst,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_IF   = 3'b001,
    S_ID   = 3'b010,
    S_EX   = 3'b011,
    S_MEM  = 3'b100,
    S_WB   = 3'b101
  } state_e;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ir_we_q, pc_we_q, rf_we_q, dm_we_q, busy_q;
  logic        retire_s;
  logic        mem_go_s;

`ifdef MEM_WAIT_EN
  assign mem_go_s = bus.mem_rdy;
`else
  logic mem_rdy_unused_s;
  assign mem_rdy_unused_s = bus.mem_rdy;
  assign mem_go_s = 1'b1;
`endif

  // Next-state, opcode capture and retire decision
  always_comb begin
    state_d  = S_IDLE;
    op_d     = op_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_IF;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IF: begin
        state_d = S_ID;
      end
      S_ID: begin
        state_d = S_EX;
        op_d    = bus.opa;
      end
      S_EX: begin
        if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_go_s) begin
          state_d = S_MEM;
        end else if (op_q == OP_SW) begin
          retire_s = 1'b1;
          state_d  = bus.run ? S_IF : S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        retire_s = 1'b1;
        state_d  = bus.run ? S_IF : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cnt_d = retire_s ? (cnt_q + 16'd1) : cnt_q;
  end

  // Strobes are registered from the next state so they stay aligned with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 6'b000000;
      cnt_q   <= 16'h0000;
      ir_we_q <= 1'b0;
      pc_we_q <= 1'b0;
      rf_we_q <= 1'b0;
      dm_we_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ir_we_q <= (state_d == S_IF);
      pc_we_q <= (state_d == S_IF);
      rf_we_q <= (state_d == S_WB);
      dm_we_q <= (state_d == S_MEM) && (op_d == OP_SW);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.state     = state_q;
  assign bus.ir_we     = ir_we_q;
  assign bus.pc_we     = pc_we_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.busy      = busy_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random stimulus
// compared each cycle against an instruction-level plan model.
module tb_cpu_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_IF   = 3'd1;
  localparam logic [2:0] ST_ID   = 3'd2;
  localparam logic [2:0] ST_EX   = 3'd3;
  localparam logic [2:0] ST_MEM  = 3'd4;
  localparam logic [2:0] ST_WB   = 3'd5;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  cpu_sequencer_if bus_if ();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: current phase plus the phases still planned for this instruction
  logic [2:0]  m_cur = ST_IDLE;
  logic [5:0]  m_op  = 6'd0;
  logic [15:0] m_cnt = 16'd0;
  logic [2:0]  m_plan[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic rn, input logic [5:0] op, input logic rdy);
    if (r) begin
      m_cur = ST_IDLE; m_op = 6'd0; m_cnt = 16'd0; m_plan.delete();
    end else if (m_cur == ST_IDLE) begin
      if (rn) begin m_cur = ST_IF; m_plan = '{ST_ID, ST_EX}; end
    end else if (m_cur == ST_MEM && WAIT_EN && !rdy) begin
      m_cur = ST_MEM;
    end else if (m_plan.size() > 0) begin
      if (m_cur == ST_ID) begin
        m_op = op;
        if (op == LW)      begin m_plan.push_back(ST_MEM); m_plan.push_back(ST_WB); end
        else if (op == SW) m_plan.push_back(ST_MEM);
        else               m_plan.push_back(ST_WB);
      end
      m_cur = m_plan.pop_front();
    end else begin
      m_cnt = m_cnt + 16'd1;
      if (rn) begin m_cur = ST_IF; m_plan = '{ST_ID, ST_EX}; end
      else m_cur = ST_IDLE;
    end
  endtask

  // One clock: drive at negedge, advance the model, compare just after posedge
  task automatic step(input logic r, input logic rn, input logic [5:0] op, input logic rdy);
    logic [4:0] exp_s, got_s;
    @(negedge clk);
    rst = r; bus_if.run = rn; bus_if.opa = op; bus_if.mem_rdy = rdy;
    model_step(r, rn, op, rdy);
    @(posedge clk); #1;
    exp_s = {m_cur == ST_IF, m_cur == ST_IF, m_cur == ST_WB,
             (m_cur == ST_MEM) && (m_op == SW), m_cur != ST_IDLE};
    got_s = {bus_if.ir_we, bus_if.pc_we, bus_if.rf_we, bus_if.dm_we, bus_if.busy};
    check_eq("state", {29'd0, bus_if.state}, {29'd0, m_cur});
    check_eq("strobes", {27'd0, got_s}, {27'd0, exp_s});
    check_eq("instr_cnt", {16'd0, bus_if.instr_cnt}, {16'd0, m_cnt});
  endtask

  logic [2:0] exp25[5] = '{ST_IF, ST_ID, ST_EX, ST_WB, ST_IF};
  int mem_cycles;

  initial begin
    bus_if.run = 1'b0; bus_if.opa = 6'd0; bus_if.mem_rdy = 1'b0;

    // Reset state
    step(1'b1, 1'b1, 6'd0, 1'b1);
    step(1'b1, 1'b0, 6'd0, 1'b0);
    check_eq("rst_state", {29'd0, bus_if.state}, 32'd0);
    check_eq("rst_busy", {31'd0, bus_if.busy}, 32'd0);

    // R-type loop: IF ID EX WB IF, one retire
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 6'd0, 1'b0);
      check_eq("seq_rtype", {29'd0, bus_if.state}, {29'd0, exp25[i]});
      check_eq("rf_we_wb", {31'd0, bus_if.rf_we}, {31'd0, exp25[i] == ST_WB});
    end
    check_eq("cnt_first", {16'd0, bus_if.instr_cnt}, 32'd1);

    // lw captured in ID, opa changed afterwards
    step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b1, LW, 1'b0);
    step(1'b0, 1'b1, 6'd0, 1'b1);
    check_eq("lw_mem", {29'd0, bus_if.state}, {29'd0, ST_MEM});
    check_eq("lw_dm_we", {31'd0, bus_if.dm_we}, 32'd0);
    step(1'b0, 1'b1, 6'd0, 1'b1);
    check_eq("lw_wb", {29'd0, bus_if.state}, {29'd0, ST_WB});
    check_eq("lw_rf_we", {31'd0, bus_if.rf_we}, 32'd1);
    step(1'b0, 1'b1, 6'd0, 1'b0);

    // sw with run dropped in EX
    step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b1, SW, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b1);
    check_eq("sw_dm_we", {31'd0, bus_if.dm_we}, 32'd1);
    step(1'b0, 1'b0, 6'd0, 1'b1);
    check_eq("sw_idle", {29'd0, bus_if.state}, 32'd0);
    check_eq("sw_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("sw_cnt", {16'd0, bus_if.instr_cnt}, 32'd3);

    // MEM duration for lw with mem_rdy low for three cycles
    step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b0);
    step(1'b0, 1'b0, LW, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b0);
    mem_cycles = (bus_if.state == ST_MEM) ? 1 : 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 6'd0, (k >= 3));
      if (bus_if.state == ST_MEM) mem_cycles++;
    end
    check_eq("mem_len", mem_cycles, WAIT_EN ? 32'd4 : 32'd1);

    // Reset during EX of an R-type abandons it
    step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b1, 1'b1, 6'd0, 1'b0);
    check_eq("rstex_state", {29'd0, bus_if.state}, 32'd0);
    check_eq("rstex_rf_we", {31'd0, bus_if.rf_we}, 32'd0);
    check_eq("rstex_cnt", {16'd0, bus_if.instr_cnt}, 32'd0);
    step(1'b0, 1'b1, 6'd0, 1'b0);
    check_eq("rstex_resume", {29'd0, bus_if.state}, {29'd0, ST_IF});

    // Counter wrap: preload to all-ones while idle, then retire one more
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
    step(1'b0, 1'b0, 6'd0, 1'b0);
    check_eq("wrap_pre", {16'd0, bus_if.instr_cnt}, 32'h0000FFFF);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b0);
    check_eq("wrap_post", {16'd0, bus_if.instr_cnt}, 32'd0);

    // Random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      logic       r_rst, r_run, r_rdy;
      logic [5:0] r_op;
      int         sel;
      r_rst = ($urandom_range(0, 99) < 2);
      r_run = ($urandom_range(0, 99) < 85);
      r_rdy = $urandom_range(0, 1) == 1;
      sel   = $urandom_range(0, 3);
      r_op  = (sel == 0) ? LW : (sel == 1) ? SW : (sel == 2) ? 6'd0 : 6'($urandom_range(0, 63));
      step(r_rst, r_run, r_op, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
